// File: rtl/core_mem_pkg.sv
// Shared types and defaults for the core's data-memory stage.
// Holds FSM/error enums and the request error classifier.
package core_mem_pkg;

  localparam int unsigned DMEM_DEPTH_DEF  = 64;
  localparam int unsigned DMEM_DATA_W_DEF = 32;
  localparam int unsigned DMEM_WAIT_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } dmem_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ALIGN,
    ERR_RANGE,
    ERR_CONFLICT
  } dmem_err_t;

  // Conflict outranks alignment, which outranks range; any of them blocks the access.
  function automatic dmem_err_t classify(input logic        rd,
                                         input logic        wr,
                                         input logic [31:0] addr,
                                         input int unsigned depth);
    if (rd && wr) return ERR_CONFLICT;
    if (addr[1:0] != 2'b00) return ERR_ALIGN;
    if (32'(addr[31:2]) >= depth) return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Word-addressed RAM: one combinational read port, two synchronous write ports.
// The commit port wins over the init port on a same-edge, same-index collision.
module data_ram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     i_cmt_we,
  input  logic [$clog2(DEPTH)-1:0] i_cmt_idx,
  input  logic [DATA_W-1:0]        i_cmt_data,
  input  logic                     i_init_we,
  input  logic [$clog2(DEPTH)-1:0] i_init_idx,
  input  logic [DATA_W-1:0]        i_init_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output logic [DATA_W-1:0]        o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_init_blocked;

  assign w_init_blocked = i_cmt_we && (i_cmt_idx == i_init_idx);

  always_ff @(posedge clk) begin
    if (i_cmt_we) r_mem[i_cmt_idx] <= i_cmt_data;
    if (i_init_we && !w_init_blocked) r_mem[i_init_idx] <= i_init_data;
  end

  assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory stage behind the core: synchronous RAM access with wait states,
// a one-cycle mem_ready/mem_error completion pulse and a preload port.
module data_mem_ctrl
  import core_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = DMEM_DEPTH_DEF,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DATA_W      = DMEM_DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [31:0]              data_address,
  input  logic [DATA_W-1:0]        write_data,
  output logic [DATA_W-1:0]        read_data,
  output logic                     mem_ready,
  output logic                     mem_error,
  input  logic                     init_we,
  input  logic [$clog2(DEPTH)-1:0] init_addr,
  input  logic [DATA_W-1:0]        init_data
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned WAIT_INIT = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;
  localparam logic [DMEM_WAIT_W-1:0] CNT_LOAD = DMEM_WAIT_W'(WAIT_INIT);

  dmem_state_t              r_state;
  logic [DMEM_WAIT_W-1:0]   r_cnt;
  logic                     r_write;
  logic [AW-1:0]            r_idx;
  logic [DATA_W-1:0]        r_wdata;
  dmem_err_t                r_err;
  logic [DATA_W-1:0]        r_read_data;
  logic                     r_ready;
  logic                     r_error;

  logic                     w_req;
  logic                     w_fast;
  logic                     w_enter_done;
  logic [AW-1:0]            w_in_idx;
  dmem_err_t                w_in_err;
  logic                     w_write;
  logic [AW-1:0]            w_idx;
  logic [DATA_W-1:0]        w_wdata;
  dmem_err_t                w_err;
  logic                     w_cmt_we;
  logic                     w_load;
  logic                     w_init_we;
  logic [DATA_W-1:0]        w_rd_data;

  assign w_req    = mem_read | mem_write;
  assign w_in_idx = data_address[AW+1:2];
  assign w_in_err = classify(mem_read, mem_write, data_address, DEPTH);

  // With no wait states the access completes on the capturing edge itself,
  // so the live request is used instead of the captured copy.
  assign w_fast       = (r_state == IDLE) && w_req && (WAIT_CYCLES == 0);
  assign w_enter_done = !rst && (w_fast || ((r_state == BUSY) && (r_cnt == '0)));

  assign w_write = w_fast ? mem_write  : r_write;
  assign w_idx   = w_fast ? w_in_idx   : r_idx;
  assign w_wdata = w_fast ? write_data : r_wdata;
  assign w_err   = w_fast ? w_in_err   : r_err;

  assign w_cmt_we  = w_enter_done && w_write && (w_err == ERR_NONE);
  assign w_load    = w_enter_done && !w_write && (w_err == ERR_NONE);
  assign w_init_we = init_we && (rst || (r_state == IDLE));

  data_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk         (clk),
    .i_cmt_we    (w_cmt_we),
    .i_cmt_idx   (w_idx),
    .i_cmt_data  (w_wdata),
    .i_init_we   (w_init_we),
    .i_init_idx  (init_addr),
    .i_init_data (init_data),
    .i_rd_idx    (w_idx),
    .o_rd_data   (w_rd_data)
  );

  // Request FSM, wait counter and registered completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_err       <= ERR_NONE;
      r_read_data <= '0;
      r_ready     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_write <= mem_write;
            r_idx   <= w_in_idx;
            r_wdata <= write_data;
            r_err   <= w_in_err;
            if (WAIT_CYCLES == 0) begin
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          if (r_cnt == '0) r_state <= DONE;
          else r_cnt <= r_cnt - DMEM_WAIT_W'(1);
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_enter_done) begin
        r_ready <= 1'b1;
        r_error <= (w_err != ERR_NONE);
      end
      if (w_load) r_read_data <= w_rd_data;
    end
  end

  assign read_data = r_read_data;
  assign mem_ready = r_ready;
  assign mem_error = r_error;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: four instances with WAIT_CYCLES 0..3, directed
// scenarios then random traffic, all checked against an array-based memory model.
module tb_data_mem_ctrl;

  localparam int unsigned N_DUT = 4;
  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read     [N_DUT];
  logic        mem_write    [N_DUT];
  logic [31:0] data_address [N_DUT];
  logic [31:0] write_data   [N_DUT];
  logic [31:0] read_data    [N_DUT];
  logic        mem_ready    [N_DUT];
  logic        mem_error    [N_DUT];
  logic        init_we      [N_DUT];
  logic [5:0]  init_addr    [N_DUT];
  logic [31:0] init_data    [N_DUT];

  logic [31:0] mdl_mem [N_DUT][DEPTH];
  logic [31:0] mdl_rd  [N_DUT];

  int          n_cmp  = 0;
  int          n_fail = 0;
  int unsigned cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    data_mem_ctrl #(
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (g),
      .DATA_W      (32)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read     (mem_read[g]),
      .mem_write    (mem_write[g]),
      .data_address (data_address[g]),
      .write_data   (write_data[g]),
      .read_data    (read_data[g]),
      .mem_ready    (mem_ready[g]),
      .mem_error    (mem_error[g]),
      .init_we      (init_we[g]),
      .init_addr    (init_addr[g]),
      .init_data    (init_data[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for mem_ready; reports the cycle stamp where it was seen.
  task automatic wait_ready(input int k, output int unsigned at, output bit ok);
    int n = 0;
    while (mem_ready[k] !== 1'b1 && n < 16) begin
      tick();
      init_we[k] = 1'b0;
      n++;
    end
    at = cyc;
    ok = (mem_ready[k] === 1'b1);
    check($sformatf("ready_seen[%0d]", k), 32'(ok), 32'd1);
  endtask

  task automatic init_word(input int k, input logic [5:0] idx, input logic [31:0] d);
    init_we[k] = 1'b1; init_addr[k] = idx; init_data[k] = d;
    tick();
    init_we[k] = 1'b0;
    mdl_mem[k][idx] = d;
  endtask

  // mode 1: init strobe on the edge after capture (must be ignored)
  // mode 2: init strobe on the capturing edge at the stored index (store must win)
  task automatic access(input int k, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int mode);
    bit          err, ok;
    int unsigned c0, c1;
    logic [5:0]  idx;
    err = (rd && wr) || (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
    idx = addr[7:2];
    mem_read[k] = rd; mem_write[k] = wr; data_address[k] = addr; write_data[k] = wd;
    if (mode == 2) begin
      init_we[k] = 1'b1; init_addr[k] = idx; init_data[k] = $urandom;
    end
    tick();
    c0 = cyc;
    init_we[k] = 1'b0;
    if (mode == 1) begin
      init_we[k] = 1'b1; init_addr[k] = idx; init_data[k] = $urandom;
    end
    data_address[k] = $urandom;
    write_data[k]   = $urandom;
    if (!err && wr) mdl_mem[k][idx] = wd;
    if (!err && rd) mdl_rd[k] = mdl_mem[k][idx];
    wait_ready(k, c1, ok);
    check($sformatf("latency[%0d]", k), 32'(c1 - c0), 32'(k));
    check($sformatf("error[%0d]", k), 32'(mem_error[k]), 32'(err));
    check($sformatf("rdata[%0d]@%0h", k, addr), read_data[k], mdl_rd[k]);
    mem_read[k] = 1'b0; mem_write[k] = 1'b0; init_we[k] = 1'b0;
    tick();
    check($sformatf("ready_pulse[%0d]", k), 32'(mem_ready[k]), 32'd0);
  endtask

  // Store then load the same word, request held high across the handover.
  task automatic b2b(input int k, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned c0, c1, c2;
    bit          ok;
    mem_read[k] = 1'b0; mem_write[k] = 1'b1; data_address[k] = addr; write_data[k] = wd;
    tick();
    c0 = cyc;
    wait_ready(k, c1, ok);
    check($sformatf("b2b_st_lat[%0d]", k), 32'(c1 - c0), 32'(k));
    check($sformatf("b2b_st_rdata[%0d]", k), read_data[k], mdl_rd[k]);
    mdl_mem[k][addr[7:2]] = wd;
    mem_write[k] = 1'b0; mem_read[k] = 1'b1;
    tick();
    check($sformatf("b2b_gap[%0d]", k), 32'(mem_ready[k]), 32'd0);
    wait_ready(k, c2, ok);
    check($sformatf("b2b_ld_lat[%0d]", k), 32'(c2 - c0), 32'(2 * k + 2));
    mdl_rd[k] = wd;
    check($sformatf("b2b_ld_rdata[%0d]", k), read_data[k], mdl_rd[k]);
    mem_read[k] = 1'b0;
    tick();
    check($sformatf("b2b_pulse[%0d]", k), 32'(mem_ready[k]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    for (int k = 0; k < N_DUT; k++) begin
      mem_read[k] = 1'b0; mem_write[k] = 1'b0; data_address[k] = '0; write_data[k] = '0;
      init_we[k] = 1'b0; init_addr[k] = '0; init_data[k] = '0; mdl_rd[k] = '0;
    end
    tick();
    tick();
    // Preload every word of every instance while in reset
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int k = 0; k < N_DUT; k++) begin
        d = (i == 0) ? 32'd8 : (i == 1) ? 32'd100 : $urandom;
        init_we[k] = 1'b1; init_addr[k] = 6'(i); init_data[k] = d;
        mdl_mem[k][i] = d;
      end
      tick();
    end
    for (int k = 0; k < N_DUT; k++) begin
      init_we[k] = 1'b0;
      check($sformatf("rst_ready[%0d]", k), 32'(mem_ready[k]), 32'd0);
      check($sformatf("rst_error[%0d]", k), 32'(mem_error[k]), 32'd0);
      check($sformatf("rst_rdata[%0d]", k), read_data[k], 32'd0);
    end
    rst = 1'b0;
    tick();

    // Basic load, store/load back-to-back, error classes
    access(1, 1'b1, 1'b0, 32'h4, 32'd0, 0);
    b2b(1, 32'h8, 32'd108);
    access(1, 1'b1, 1'b0, 32'h6, 32'd0, 0);
    access(1, 1'b0, 1'b1, 32'h100, 32'h1234_5678, 0);
    access(1, 1'b1, 1'b1, 32'h0, 32'h0000_0055, 0);
    access(1, 1'b1, 1'b0, 32'h0, 32'd0, 0);
    for (int k = 0; k < N_DUT; k++) b2b(k, {24'd0, 6'(4 + k), 2'b00}, $urandom);

    // Reset on the edge that would commit a pending store
    mem_write[3] = 1'b1; data_address[3] = 32'hC; write_data[3] = 32'hDEAD_BEEF;
    tick();
    mem_write[3] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < N_DUT; k++) mdl_rd[k] = '0;
    check("abort_ready", 32'(mem_ready[3]), 32'd0);
    check("abort_error", 32'(mem_error[3]), 32'd0);
    check("abort_rdata", read_data[3], 32'd0);
    tick();
    tick();
    check("abort_no_late_ready", 32'(mem_ready[3]), 32'd0);
    access(3, 1'b1, 1'b0, 32'hC, 32'd0, 0);

    // Zero wait states, and init strobes outside IDLE / on the capture edge
    access(0, 1'b1, 1'b0, 32'h0, 32'd0, 0);
    access(2, 1'b1, 1'b0, 32'h10, 32'd0, 1);
    access(2, 1'b1, 1'b0, 32'h10, 32'd0, 0);
    access(0, 1'b0, 1'b1, 32'h14, 32'hA5A5_0001, 2);
    access(0, 1'b1, 1'b0, 32'h14, 32'd0, 0);
    access(1, 1'b0, 1'b1, 32'h18, 32'hA5A5_0002, 2);
    access(1, 1'b1, 1'b0, 32'h18, 32'd0, 0);

    // Random traffic
    for (int k = 0; k < N_DUT; k++) begin
      for (int it = 0; it < 30; it++) begin
        logic [31:0] a, w;
        bit          rd, wr;
        int          mode;
        int unsigned r, o;
        r = $urandom_range(0, 9);
        a = {24'd0, 6'($urandom_range(0, (r < 5) ? 7 : 63)), 2'b00};
        if (r == 8) a[1:0] = 2'($urandom_range(1, 3));
        if (r == 9) begin
          w = $urandom_range(64, 32'h3FFF_FFFF);
          a = {w[29:0], 2'b00};
        end
        o  = $urandom_range(0, 9);
        rd = (o < 5) || (o == 9);
        wr = (o >= 5);
        mode = 0;
        if (wr && !rd && r < 8 && $urandom_range(0, 3) == 0) mode = 2;
        else if ($urandom_range(0, 3) == 0) mode = 1;
        access(k, rd, wr, a, $urandom, mode);
        if ($urandom_range(0, 7) == 0) init_word(k, 6'($urandom_range(0, 7)), $urandom);
      end
    end

    // Read back every word
    for (int k = 0; k < N_DUT; k++)
      for (int i = 0; i < int'(DEPTH); i++)
        access(k, 1'b1, 1'b0, {24'd0, 6'(i), 2'b00}, 32'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
